// File: rtl/ws_output_deskew_acc.sv
// ws_output_deskew_acc
// -----------------------------------------------------------------------------
// Output stage of a weight-stationary systolic array. Column c of a result
// vector leaves the array c cycles after column 0. This block re-aligns the
// columns, accumulates partial sums across passes into a small vector buffer,
// and queues finished vectors in an output FIFO with a valid/ready handshake.
//
// Build option:
//   WS_ACC_SATURATE_EN  - when defined, accumulation clamps to the signed
//                         32-bit range; otherwise it wraps (two's complement).
//
// Parameters:
//   SIZE        number of array columns
//   ACC_DEPTH   accumulator buffer entries (max vectors per pass)
//   FIFO_DEPTH  output FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous flush of pipeline, index, FIFO and overflow
//   sum_in            skewed column sums from the array
//   sum_valid_in      column 0 of a result vector is present this cycle
//   first_pass_in     overwrite the accumulator entry instead of adding
//   last_pass_in      emit the accumulated vector
//   last_vec_in       final vector of the pass (entry index returns to 0)
//   out_data          aligned, accumulated vector (0 while FIFO empty)
//   out_valid/ready   output handshake
//   overflow          sticky: a FIFO push was dropped
//   busy              a beat is in flight or the FIFO is non-empty
// -----------------------------------------------------------------------------
module ws_output_deskew_acc #(
  parameter int SIZE       = 16,
  parameter int ACC_DEPTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [SIZE-1:0][31:0] sum_in,
  input  logic                  sum_valid_in,
  input  logic                  first_pass_in,
  input  logic                  last_pass_in,
  input  logic                  last_vec_in,
  output logic [SIZE-1:0][31:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  busy
);

  localparam int DLY   = SIZE - 1;
  localparam int IDX_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ACC_DEPTH - 1);

  // Add two signed 32-bit values, clamping or wrapping depending on the build.
  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
`ifdef WS_ACC_SATURATE_EN
    // Sign of the 33-bit sum differs from bit 31 only on signed overflow.
    if (s[32] != s[31]) begin
      acc_add = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      acc_add = s[31:0];
    end
`else
    acc_add = s[31:0];
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Deskew: control flags ride a SIZE-1 deep pipe, column c a SIZE-1-c deep pipe
  // ---------------------------------------------------------------------------
  logic [3:0]            ctl_in_s;   // {valid, first, last, last_vec}
  logic [3:0]            ctl_al_s;
  logic                  pipe_any_s;
  logic [SIZE-1:0][31:0] data_al_s;

  assign ctl_in_s = {sum_valid_in, first_pass_in, last_pass_in, last_vec_in};

  generate
    if (DLY > 0) begin : g_ctl
      logic [3:0] ctl_r [DLY];

      // Control delay line; clear drops every in-flight beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DLY; i++) ctl_r[i] <= 4'd0;
        end else if (clear) begin
          for (int i = 0; i < DLY; i++) ctl_r[i] <= 4'd0;
        end else begin
          ctl_r[0] <= ctl_in_s;
          for (int i = 1; i < DLY; i++) ctl_r[i] <= ctl_r[i-1];
        end
      end

      // Any valid beat still travelling through the deskew pipe.
      always_comb begin
        pipe_any_s = 1'b0;
        for (int i = 0; i < DLY; i++) pipe_any_s = pipe_any_s | ctl_r[i][3];
      end

      assign ctl_al_s = ctl_r[DLY-1];
    end else begin : g_ctl_direct
      assign ctl_al_s   = ctl_in_s;
      assign pipe_any_s = 1'b0;
    end

    for (genvar c = 0; c < SIZE; c++) begin : g_col
      localparam int D = SIZE - 1 - c;
      if (D == 0) begin : g_pass
        assign data_al_s[c] = sum_in[c];
      end else begin : g_dly
        logic [31:0] pipe_r [D];

        // Per-column data delay line (data needs no flush, valid bits gate it).
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int i = 0; i < D; i++) pipe_r[i] <= 32'd0;
          end else begin
            pipe_r[0] <= sum_in[c];
            for (int i = 1; i < D; i++) pipe_r[i] <= pipe_r[i-1];
          end
        end

        assign data_al_s[c] = pipe_r[D-1];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Accumulation
  // ---------------------------------------------------------------------------
  logic                  beat_s;
  logic                  first_al_s;
  logic                  last_al_s;
  logic                  last_vec_al_s;
  logic [IDX_W-1:0]      idx_r;
  logic [SIZE-1:0][31:0] acc_buf_r [ACC_DEPTH];
  logic [SIZE-1:0][31:0] result_s;
  logic [SIZE-1:0][31:0] res_r;
  logic                  res_valid_r;

  assign beat_s        = ctl_al_s[3] & ~clear;
  assign first_al_s    = ctl_al_s[2];
  assign last_al_s     = ctl_al_s[1];
  assign last_vec_al_s = ctl_al_s[0];

  // Per-column result: overwrite on the first pass, otherwise add to the entry.
  always_comb begin
    result_s = data_al_s;
    for (int c = 0; c < SIZE; c++) begin
      if (first_al_s) begin
        result_s[c] = data_al_s[c];
      end else begin
        result_s[c] = acc_add(acc_buf_r[idx_r][c], data_al_s[c]);
      end
    end
  end

  // Accumulator storage; contents are meaningless until a first pass writes them.
  always_ff @(posedge clk) begin
    if (beat_s) acc_buf_r[idx_r] <= result_s;
  end

  // Entry index: step per beat, back to 0 after the last vector or at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (clear) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (beat_s) begin
      if (last_vec_al_s || (idx_r == IDX_MAX)) idx_r <= {IDX_W{1'b0}};
      else                                     idx_r <= idx_r + IDX_W'(1);
    end
  end

  // Result register feeding the FIFO one cycle after alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_r       <= {(SIZE*32){1'b0}};
    end else if (clear) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= beat_s & last_al_s;
      if (beat_s && last_al_s) res_r <= result_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [SIZE-1:0][31:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  push_ok_s;
  logic                  drop_s;
  logic                  overflow_r;

  assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign pop_s     = out_valid & out_ready;
  assign push_s    = res_valid_r & ~clear;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign drop_s    = push_s & full_s & ~pop_s;

  // Next occupancy from push/pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_ok_s && !pop_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (!push_ok_s && pop_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) fifo_mem_r[wr_ptr_r] <= res_r;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_nxt_s;
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // Empty FIFO shows zeros so stale or uninitialised storage never leaks out.
  assign out_data = out_valid ? fifo_mem_r[rd_ptr_r] : {(SIZE*32){1'b0}};
  assign overflow = overflow_r;
  assign busy     = pipe_any_s | res_valid_r | out_valid;

endmodule

// File: doc/ws_output_deskew_acc.md
WS_OUTPUT_DESKEW_ACC -- requirements
Module: ws_output_deskew_acc

Interface
REQ-001 SHALL have parameter SIZE, default 16: number of systolic array columns.
REQ-002 SHALL have parameter ACC_DEPTH, default 16: accumulator buffer entries (max vectors per pass).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush.
REQ-007 SHALL have port sum_in, input, [SIZE] x signed 32 bits: array column outputs; column c is valid c cycles after column 0.
REQ-008 SHALL have port sum_valid_in, input, 1 bit: column 0 of a result vector is present this cycle.
REQ-009 SHALL have port first_pass_in, input, 1 bit: sampled with sum_valid_in; overwrite instead of accumulate.
REQ-010 SHALL have port last_pass_in, input, 1 bit: sampled with sum_valid_in; emit the result.
REQ-011 SHALL have port last_vec_in, input, 1 bit: sampled with sum_valid_in; final vector of the pass.
REQ-012 SHALL have port out_data, output, [SIZE] x signed 32 bits: aligned, accumulated vector.
REQ-013 SHALL have port out_valid, output, 1 bit; port out_ready, input, 1 bit: out_data transfers when both are high.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, FIFO push dropped.
REQ-015 SHALL have port busy, output, 1 bit: deskew holds a valid beat or FIFO is non-empty.

Function
REQ-016 SHALL delay column c by SIZE-1-c registers, so all columns of a vector align at cycle t+SIZE-1, where t is the sum_valid_in cycle.
REQ-017 SHALL delay sum_valid_in, first_pass_in, last_pass_in and last_vec_in by SIZE-1 registers so they align with the data.
REQ-018 SHALL hold an entry index idx, 0..ACC_DEPTH-1, that selects the accumulator entry for each aligned beat.
REQ-019 SHALL advance idx by 1 after each aligned valid beat, reset it to 0 after a beat flagged last_vec, and wrap it from ACC_DEPTH-1 to 0.
REQ-020 SHALL compute the per-column result as aligned sum if first_pass is set, otherwise as buf[idx][c] + aligned sum.
REQ-021 SHALL write the result back to buf[idx] on every aligned valid beat.
REQ-022 SHALL register the result when last_pass is set and push it into the FIFO at the end of cycle t+SIZE.
REQ-023 SHALL present the pushed vector with out_valid=1 from cycle t+SIZE+1 when the FIFO was empty, giving a total latency of SIZE+1 cycles.
REQ-024 SHALL drop a push arriving while the FIFO is full with no pop in the same cycle, and set overflow.
REQ-025 SHALL accept a push into a full FIFO when a pop occurs in the same cycle, with count unchanged.
REQ-026 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL never stall upstream; there is no input-side ready.
REQ-028 SHALL, on clear, zero all deskew valid bits, idx, FIFO pointers and overflow, and discard in-flight beats; clear overrides a simultaneous input or push.
REQ-029 SHALL leave accumulator buffer contents undefined after reset and clear; correctness relies on first_pass.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force out_valid=0, overflow=0, busy=0, idx=0, FIFO empty and all deskew valid bits 0.
REQ-031 SHALL drive out_data to 0 while the FIFO is empty after reset.
REQ-032 SHALL lose any beat in flight when reset is asserted mid-operation; the first output after reset is the first vector accepted after release.

Configuration
REQ-033 SHALL, with WS_ACC_SATURATE_EN defined, clamp each accumulate result to the range -2147483648 to 2147483647.
REQ-034 SHALL, without WS_ACC_SATURATE_EN, wrap each accumulate result in two's complement 32-bit arithmetic.

Verification
REQ-035 Single pass, SIZE=4: sum_valid_in at t=0 with first=last=last_vec=1 and columns carrying 10,20,30,40 at t=0,1,2,3 -> out_valid at t=5 with out_data = {10,20,30,40}.
REQ-036 Three passes, column value 7, first on pass 1, last on pass 3, one vector per pass -> single output of 21 per column; no output for passes 1 and 2.
REQ-037 Two vectors per pass (last_vec on the second), two passes with values 1,2 then 3,4 -> outputs 4 then 6, in order.
REQ-038 out_ready=0 with FIFO_DEPTH=4 and 5 emitted vectors -> first 4 retained, 5th dropped, overflow=1; clear -> overflow=0 and out_valid=0.
REQ-039 Accumulate 2147483647 + 1 -> 2147483647 with WS_ACC_SATURATE_EN defined, -2147483648 without it.
REQ-040 rst_n low for 1 cycle at t=2 of an in-flight vector -> no output appears, busy=0 immediately, and a subsequent vector completes with nominal latency.
